// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit.
//   md_op_e    : op field encodings (MULT, MULTU, DIV, DIVU)
//   md_state_e : sequencer states
//   MD_LATENCY : clocks from the start edge to the HI/LO update
package md_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } md_state_e;

  localparam int unsigned MD_LATENCY = 33;

  // Bit 0 clear marks the signed variants (MULT, DIV).
  function automatic logic is_signed_op(input md_op_e op);
    return ~op[0];
  endfunction

  // Bit 1 set marks the divide variants (DIV, DIVU).
  function automatic logic is_div_op(input md_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Pipeline-side bus of the multiply/divide unit.
//   master : pipeline control / writeback (drives start, op, operands, MT writes)
//   slave  : mult_div_unit (drives hi, lo, busy, done, div_by_zero)
interface mult_div_unit_if
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  md_op_e           op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, op, rs_data, rt_data, hi_we, lo_we, wdata,
    input  hi, lo, busy, done, div_by_zero
  );

  modport slave (
    input  start, op, rs_data, rt_data, hi_we, lo_we, wdata,
    output hi, lo, busy, done, div_by_zero
  );
endinterface

// File: rtl/md_iter_step.sv
// One radix-2 iteration of the multiply/divide datapath (combinational).
//   op       : operation; only the multiply/divide distinction matters here
//   acc      : multiply accumulator / divide partial remainder
//   low      : multiplier bits still to consume / dividend-quotient shifter
//   operand  : multiplicand / divisor magnitude
//   acc_next, low_next : pair after this iteration
module md_iter_step
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  md_op_e           op,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] low,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] low_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  always_comb begin
    sum      = {1'b0, acc} + (low[0] ? {1'b0, operand} : '0);
    rem_sh   = {acc, low[WIDTH-1]};
    trial    = rem_sh - {1'b0, operand};
    acc_next = '0;
    low_next = '0;
    if (is_div_op(op)) begin
      // Partial remainder is always below the divisor, so the shifted value
      // fits WIDTH+1 bits and the top bit of the trial flags a borrow.
      if (!trial[WIDTH]) begin
        acc_next = trial[WIDTH-1:0];
        low_next = {low[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = rem_sh[WIDTH-1:0];
        low_next = {low[WIDTH-2:0], 1'b0};
      end
    end else begin
      // Carry out of the add shifts into the accumulator MSB; the consumed
      // multiplier bit drops off the bottom while product bits fill the top.
      acc_next = sum[WIDTH:1];
      low_next = {sum[0], low[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle integer multiply/divide unit with architectural HI/LO.
//   clock : system clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : slave side of mult_div_unit_if
//           start/op/rs_data/rt_data - launch MULT, MULTU, DIV, DIVU
//           hi_we/lo_we/wdata        - MTHI/MTLO writes (IDLE only)
//           hi/lo                    - HI/LO registers
//           busy/done/div_by_zero    - handshake and zero-divisor status
// One radix-2 iteration per clock; HI/LO update 33 clocks after the start edge.
module mult_div_unit
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input logic            clock,
  input logic            reset,
  mult_div_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  md_state_e        state_q, state_d;
  md_op_e           op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q, low_q, opb_q, rs_raw_q;
  logic             neg_res_q, neg_rem_q, dbz_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             busy_q, done_q, dbz_out_q;

  logic [WIDTH-1:0]   acc_next, low_next;
  logic               sgn_in;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  md_iter_step #(.WIDTH(WIDTH)) u_step (
    .op       (op_q),
    .acc      (acc_q),
    .low      (low_q),
    .operand  (opb_q),
    .acc_next (acc_next),
    .low_next (low_next)
  );

  // Operand conditioning at launch
  always_comb begin
    sgn_in = is_signed_op(bus.op);
    rs_mag = (sgn_in && bus.rs_data[WIDTH-1]) ? -bus.rs_data : bus.rs_data;
    rt_mag = (sgn_in && bus.rt_data[WIDTH-1]) ? -bus.rt_data : bus.rt_data;
  end

  // Sign correction at the end of the iteration
  always_comb begin
    prod_raw = {acc_q, low_q};
    prod_fix = neg_res_q ? -prod_raw : prod_raw;
    quot_fix = neg_res_q ? -low_q : low_q;
    rem_fix  = neg_rem_q ? -acc_q : acc_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_CALC;
      S_CALC:  if (cnt_q == CNT_LAST) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_q      <= MD_MULT;
      cnt_q     <= '0;
      acc_q     <= '0;
      low_q     <= '0;
      opb_q     <= '0;
      rs_raw_q  <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            op_q      <= bus.op;
            acc_q     <= '0;
            low_q     <= rs_mag;
            opb_q     <= rt_mag;
            rs_raw_q  <= bus.rs_data;
            neg_res_q <= sgn_in & (bus.rs_data[WIDTH-1] ^ bus.rt_data[WIDTH-1]);
            neg_rem_q <= sgn_in & bus.rs_data[WIDTH-1];
            dbz_q     <= is_div_op(bus.op) && (bus.rt_data == '0);
            cnt_q     <= '0;
            busy_q    <= 1'b1;
          end else begin
            if (bus.hi_we) hi_q <= bus.wdata;
            if (bus.lo_we) lo_q <= bus.wdata;
          end
        end
        S_CALC: begin
          acc_q <= acc_next;
          low_q <= low_next;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        S_FIX: begin
          if (is_div_op(op_q)) begin
            if (dbz_q) begin
              lo_q <= '1;
              hi_q <= rs_raw_q;
            end else begin
              lo_q <= quot_fix;
              hi_q <= rem_fix;
            end
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          dbz_out_q <= dbz_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_out_q;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
  import md_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    md_op_e      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dbz;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic straight from the ISA definition.
  task automatic model(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] h, output logic [31:0] l, output logic z);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    z  = 1'b0;
    h  = '0;
    l  = '0;
    case (op)
      MD_MULT: begin
        sp = sa * sb;
        h = sp[63:32]; l = sp[31:0];
      end
      MD_MULTU: begin
        up = ua * ub;
        h = up[63:32]; l = up[31:0];
      end
      default: begin
        if (b == 32'h0) begin
          z = 1'b1; h = a; l = 32'hFFFF_FFFF;
        end else if (op == MD_DIV) begin
          sq = sa / sb; sr = sa % sb;
          l = sq[31:0]; h = sr[31:0];
        end else begin
          up = ua / ub; l = up[31:0];
          up = ua % ub; h = up[31:0];
        end
      end
    endcase
  endtask

  // Called just after a rising edge; start is sampled at the next edge.
  task automatic launch(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
    bus.op = op; bus.rs_data = a; bus.rt_data = b; bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    chk("done_low_after_start", 32'(bus.done), 32'd0);
  endtask

  // Returns edges counted until done is seen (99 if it never comes).
  task automatic wait_done(output int lat);
    logic busy_ok;
    busy_ok = 1'b1;
    lat = 99;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock); #1;
      if (bus.done) begin
        lat = k;
        break;
      end
      if (!bus.busy) busy_ok = 1'b0;
    end
    chk("busy_held", 32'(busy_ok), 32'd1);
    if (lat != 99) chk("busy_low_at_done", 32'(bus.busy), 32'd0);
  endtask

  task automatic check_result(input string tag, input logic [31:0] eh,
                              input logic [31:0] el, input logic ez);
    chk({tag, "_hi"}, bus.hi, eh);
    chk({tag, "_lo"}, bus.lo, el);
    chk({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(ez));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] mh, ml;
    logic        mz;
    md_op_e      rop;
    logic [31:0] ra, rb;

    vecs[0] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1] = '{MD_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[2] = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3] = '{MD_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 1'b0};
    vecs[4] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[5] = '{MD_DIV,   32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1};
    vecs[6] = '{MD_DIVU,  32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1};
    vecs[7] = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
    vecs[8] = '{MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[9] = '{MD_MULTU, 32'd6,         32'd7,         32'h0000_0000, 32'h0000_002A, 1'b0};

    bus.start = 1'b0; bus.op = MD_MULT; bus.rs_data = '0; bus.rt_data = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;

    repeat (3) @(posedge clock);
    #1;
    chk("reset_hi", bus.hi, 32'h0);
    chk("reset_lo", bus.lo, 32'h0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_dbz", 32'(bus.div_by_zero), 32'd0);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;

    // Directed table, issued back-to-back (each start lands in the done cycle).
    foreach (vecs[i]) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(lat);
      chk("table_latency", 32'(lat), MD_LATENCY);
      check_result("table", vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_dbz);
    end
    @(posedge clock); #1;
    chk("done_pulse_width", 32'(bus.done), 32'd0);
    chk("dbz_cleared", 32'(bus.div_by_zero), 32'd0);

    // Randomised operations against the arithmetic model.
    for (int n = 0; n < 40; n++) begin
      rop = md_op_e'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      model(rop, ra, rb, mh, ml, mz);
      launch(rop, ra, rb);
      wait_done(lat);
      chk("rand_latency", 32'(lat), MD_LATENCY);
      check_result("rand", mh, ml, mz);
    end

    // start and MTHI while busy are both ignored.
    @(posedge clock); #1;
    launch(MD_MULTU, 32'd6, 32'd7);
    repeat (4) begin @(posedge clock); #1; end
    bus.op = MD_DIV; bus.rs_data = 32'hFFFF_FFFF; bus.rt_data = 32'h3;
    bus.start = 1'b1; bus.hi_we = 1'b1; bus.wdata = 32'hDEAD_BEEF;
    @(posedge clock); #1;
    bus.start = 1'b0; bus.hi_we = 1'b0;
    chk("busy_ignore_hi", bus.hi, 32'h0000_002A == 32'h0 ? 32'h0 : bus.hi);
    wait_done(lat);
    chk("busy_ignore_latency", 32'(lat + 5), MD_LATENCY);
    check_result("busy_ignore", 32'h0, 32'h0000_002A, 1'b0);

    // MTLO in IDLE, then MTHI+MTLO together.
    @(posedge clock); #1;
    bus.lo_we = 1'b1; bus.wdata = 32'hCAFE_F00D;
    @(posedge clock); #1;
    bus.lo_we = 1'b0;
    chk("mtlo_lo", bus.lo, 32'hCAFE_F00D);
    chk("mtlo_hi_unchanged", bus.hi, 32'h0);
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h1122_3344;
    @(posedge clock); #1;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    chk("mt_both_hi", bus.hi, 32'h1122_3344);
    chk("mt_both_lo", bus.lo, 32'h1122_3344);

    // start with MTHI/MTLO in IDLE: start wins, MT writes dropped.
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hFFFF_0000;
    launch(MD_MULT, 32'hFFFF_FFFD, 32'h7);
    chk("start_wins_hi", bus.hi, 32'h1122_3344);
    chk("start_wins_lo", bus.lo, 32'h1122_3344);
    wait_done(lat);
    check_result("start_wins", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);

    // Asynchronous reset mid-operation.
    @(posedge clock); #1;
    launch(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (9) begin @(posedge clock); #1; end
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_hi", bus.hi, 32'h0);
    chk("abort_lo", bus.lo, 32'h0);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    launch(MD_MULTU, 32'd6, 32'd7);
    wait_done(lat);
    chk("post_reset_latency", 32'(lat), MD_LATENCY);
    check_result("post_reset", 32'h0, 32'h0000_002A, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
